proj_index_sequencer: RTL and testbench

- Programmable index generator that sweeps read/write indices across several feature-map (FM) buffers for the sort/MinHash datapath.
- Generalises the single-buffer free-running counter in three ways:
  - per-run programmable length and buffer count;
  - start/busy/done control;
  - valid/advance flow control, so the downstream stage can stall it.
- Sits between the controller FSM and the FM buffer address ports.

---
 rtl/proj_pkg.sv | 19 +
 rtl/proj_wrap_counter.sv | 70 +++++++
 rtl/proj_index_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_proj_index_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// proj_pkg: shared sizing constants and types for the FM index sequencer.
//   FM_BUFFER_SIZE : maximum entries per feature-map buffer
//   NUM_FM_BUF     : number of feature-map buffers swept per run
//   IDX_W / BUF_W  : derived index and buffer-select widths
//   seq_state_t    : sequencer FSM state encoding
package proj_pkg;

  localparam int unsigned FM_BUFFER_SIZE = 16;
  localparam int unsigned NUM_FM_BUF     = 4;
  localparam int unsigned IDX_W          = $clog2(FM_BUFFER_SIZE);
  localparam int unsigned BUF_W          = (NUM_FM_BUF > 1) ? $clog2(NUM_FM_BUF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/proj_wrap_counter.sv
// proj_wrap_counter: W-bit counter that wraps at a programmable limit.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : force count to 0 (highest priority after reset)
//   en_i         : step the counter by one
//   limit_i      : last value of an ascending sweep (wrap point)
//   count_o      : registered count
//   wrap_o       : count sits on its final value (limit, or 0 when counting down)
// With PROJ_IDX_SEQ_REVERSE_EN defined, two extra inputs appear:
//   load_i       : force count to limit_i
//   down_i       : count down from limit_i to 0 and reload limit_i on wrap
module proj_wrap_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
`ifdef PROJ_IDX_SEQ_REVERSE_EN
  input  logic         load_i,
  input  logic         down_i,
`endif
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         down_s;
  logic         load_s;

`ifdef PROJ_IDX_SEQ_REVERSE_EN
  assign down_s = down_i;
  assign load_s = load_i;
`else
  assign down_s = 1'b0;
  assign load_s = 1'b0;
`endif

  assign wrap_o  = down_s ? (count_q == {W{1'b0}}) : (count_q == limit_i);
  assign count_o = count_q;

  // Next count: clear, load, or step with wrap back to the sweep origin.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (load_s) begin
      count_d = limit_i;
    end else if (en_i) begin
      if (wrap_o) begin
        count_d = down_s ? limit_i : {W{1'b0}};
      end else begin
        count_d = down_s ? (count_q - W'(1)) : (count_q + W'(1));
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/proj_index_sequencer.sv
// proj_index_sequencer: sweeps index/buf_sel across len entries of nbuf
// feature-map buffers, with start/abort control and valid/advance stalling.
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : begin a run (IDLE only) / drop the run without done
//   cfg_len         : entries per buffer, clamped to 1..FM_BUFFER_SIZE at start
//   cfg_nbuf        : buffers per run, clamped to 1..NUM_BUF at start
//   advance         : downstream accepts the current beat
//   busy, valid     : run in progress / index and buf_sel are meaningful
//   index, buf_sel  : current entry and buffer
//   last_in_buf     : current beat is the final entry of its buffer
//   finished_count  : one-cycle pulse after the final beat is accepted
// Optional build macro PROJ_IDX_SEQ_REVERSE_EN adds input dir (latched at
// start); dir=1 sweeps each buffer from len-1 down to 0.
module proj_index_sequencer #(
  parameter int FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE,
  parameter int NUM_BUF        = proj_pkg::NUM_FM_BUF,
  parameter int IDX_W          = $clog2(FM_BUFFER_SIZE),
  parameter int BUF_W          = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W:0]   cfg_len,
  input  logic [BUF_W:0]   cfg_nbuf,
  input  logic             advance,
`ifdef PROJ_IDX_SEQ_REVERSE_EN
  input  logic             dir,
`endif
  output logic             busy,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic [BUF_W-1:0] buf_sel,
  output logic             last_in_buf,
  output logic             finished_count
);

  import proj_pkg::*;

  localparam logic [IDX_W:0] LEN_MAX  = (IDX_W+1)'(FM_BUFFER_SIZE);
  localparam logic [BUF_W:0] NBUF_MAX = (BUF_W+1)'(NUM_BUF);

  seq_state_t       state_q, state_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [BUF_W:0]   nbuf_q, nbuf_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             fin_q, fin_d;

  logic [IDX_W:0]   len_clamp_s;
  logic [BUF_W:0]   nbuf_clamp_s;
  logic [IDX_W:0]   cur_len_s;
  logic [IDX_W-1:0] idx_limit_s;
  logic [BUF_W-1:0] buf_limit_s;
  logic             accept_s;
  logic             ctr_init_s;
  logic             idx_wrap_s;
  logic             buf_wrap_s;
  logic             idx_clr_s;
  logic [IDX_W-1:0] idx_count_s;
  logic [BUF_W-1:0] buf_count_s;

`ifdef PROJ_IDX_SEQ_REVERSE_EN
  logic             dir_q, dir_d;
  logic             down_s;
  logic             idx_load_s;

  // Before a run is latched the counter must already see the incoming direction.
  assign down_s     = (state_q == IDLE) ? dir : dir_q;
  assign idx_clr_s  = ctr_init_s & ~down_s;
  assign idx_load_s = ctr_init_s & down_s;
`else
  assign idx_clr_s  = ctr_init_s;
`endif

  assign accept_s = valid_q & advance;

  // Out-of-range configuration falls back to the full-size sweep.
  always_comb begin
    if ((cfg_len == {(IDX_W+1){1'b0}}) || (cfg_len > LEN_MAX)) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = cfg_len;
    end
    if ((cfg_nbuf == {(BUF_W+1){1'b0}}) || (cfg_nbuf > NBUF_MAX)) begin
      nbuf_clamp_s = NBUF_MAX;
    end else begin
      nbuf_clamp_s = cfg_nbuf;
    end
  end

  // In IDLE the index counter is preloaded from the incoming config, not the stale latch.
  assign cur_len_s   = (state_q == IDLE) ? len_clamp_s : len_q;
  assign idx_limit_s = IDX_W'(cur_len_s - (IDX_W+1)'(1));
  assign buf_limit_s = BUF_W'(nbuf_q - (BUF_W+1)'(1));

  proj_wrap_counter #(.W(IDX_W)) u_idx_ctr (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (idx_clr_s),
    .en_i    (accept_s),
`ifdef PROJ_IDX_SEQ_REVERSE_EN
    .load_i  (idx_load_s),
    .down_i  (down_s),
`endif
    .limit_i (idx_limit_s),
    .count_o (idx_count_s),
    .wrap_o  (idx_wrap_s)
  );

  proj_wrap_counter #(.W(BUF_W)) u_buf_ctr (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (ctr_init_s),
    .en_i    (accept_s & idx_wrap_s),
`ifdef PROJ_IDX_SEQ_REVERSE_EN
    .load_i  (1'b0),
    .down_i  (1'b0),
`endif
    .limit_i (buf_limit_s),
    .count_o (buf_count_s),
    .wrap_o  (buf_wrap_s)
  );

  // FSM next state, config latch and registered-output next values.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    nbuf_d     = nbuf_q;
    ctr_init_s = 1'b0;
`ifdef PROJ_IDX_SEQ_REVERSE_EN
    dir_d      = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d    = RUN;
          len_d      = len_clamp_s;
          nbuf_d     = nbuf_clamp_s;
          ctr_init_s = 1'b1;
`ifdef PROJ_IDX_SEQ_REVERSE_EN
          dir_d      = dir;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // abort outranks an acceptance in the same cycle
        if (abort) begin
          state_d    = IDLE;
          ctr_init_s = 1'b1;
        end else if (accept_s && idx_wrap_s && buf_wrap_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d    = IDLE;
        ctr_init_s = abort;
      end
      default: begin
        state_d    = IDLE;
        ctr_init_s = 1'b1;
      end
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == RUN);
    fin_d   = (state_d == DONE);
  end

  // State, configuration and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= LEN_MAX;
      nbuf_q  <= NBUF_MAX;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
`ifdef PROJ_IDX_SEQ_REVERSE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      nbuf_q  <= nbuf_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
`ifdef PROJ_IDX_SEQ_REVERSE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign valid          = valid_q;
  assign index          = idx_count_s;
  assign buf_sel        = buf_count_s;
  assign last_in_buf    = valid_q & idx_wrap_s;
  assign finished_count = fin_q;

endmodule

// File: tb/tb_proj_index_sequencer.sv
// tb_proj_index_sequencer: directed self-checking bench for proj_index_sequencer.
// Expected sequences are generated from hand-computed effective len/nbuf values.
module tb_proj_index_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       advance = 1'b0;
  logic [4:0] cfg_len = 5'd0;
  logic [2:0] cfg_nbuf = 3'd0;
`ifdef PROJ_IDX_SEQ_REVERSE_EN
  logic       dir = 1'b0;
`endif
  logic       busy;
  logic       valid;
  logic [3:0] index;
  logic [1:0] buf_sel;
  logic       last_in_buf;
  logic       finished_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  proj_index_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_len        (cfg_len),
    .cfg_nbuf       (cfg_nbuf),
    .advance        (advance),
`ifdef PROJ_IDX_SEQ_REVERSE_EN
    .dir            (dir),
`endif
    .busy           (busy),
    .valid          (valid),
    .index          (index),
    .buf_sel        (buf_sel),
    .last_in_buf    (last_in_buf),
    .finished_count (finished_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, " busy"}, 32'(busy), 32'd0);
    check_val({tag, " valid"}, 32'(valid), 32'd0);
    check_val({tag, " index"}, 32'(index), 32'd0);
    check_val({tag, " buf_sel"}, 32'(buf_sel), 32'd0);
    check_val({tag, " fin"}, 32'(finished_count), 32'd0);
  endtask

  // Start a run and follow it beat by beat to the done pulse.
  task automatic run_seq(input int cl, input int cn, input int el, input int en,
                         input bit stall, input bit rev, input string tag);
    int beats;
    int cyc;
    int ei;
    int eb;
    int lasts;
    bit adv;
    cfg_len  = 5'(cl);
    cfg_nbuf = 3'(cn);
`ifdef PROJ_IDX_SEQ_REVERSE_EN
    dir = rev;
`endif
    start   = 1'b1;
    advance = 1'b1;
    step();
    start = 1'b0;
    beats = 0;
    cyc   = 0;
    ei    = rev ? el - 1 : 0;
    eb    = 0;
    lasts = 0;
    while (beats < el * en && cyc < 2000) begin
      adv     = stall ? (cyc % 2 == 0) : 1'b1;
      advance = adv;
      check_val($sformatf("%s valid b%0d", tag, beats), 32'(valid), 32'd1);
      check_val($sformatf("%s index b%0d", tag, beats), 32'(index), 32'(ei));
      check_val($sformatf("%s buf b%0d", tag, beats), 32'(buf_sel), 32'(eb));
      check_val($sformatf("%s last b%0d", tag, beats), 32'(last_in_buf),
                ((rev ? (ei == 0) : (ei == el - 1)) ? 32'd1 : 32'd0));
      check_val($sformatf("%s fin b%0d", tag, beats), 32'(finished_count), 32'd0);
      if (adv && last_in_buf) lasts++;
      step();
      if (adv) begin
        beats++;
        if (rev ? (ei == 0) : (ei == el - 1)) begin
          ei = rev ? el - 1 : 0;
          eb++;
        end else begin
          ei = rev ? ei - 1 : ei + 1;
        end
      end
      cyc++;
    end
    advance = 1'b1;
    check_val({tag, " beats"}, 32'(beats), 32'(el * en));
    check_val({tag, " last count"}, 32'(lasts), 32'(en));
    check_val({tag, " done fin"}, 32'(finished_count), 32'd1);
    check_val({tag, " done valid"}, 32'(valid), 32'd0);
    check_val({tag, " done busy"}, 32'(busy), 32'd1);
    step();
    check_val({tag, " post fin"}, 32'(finished_count), 32'd0);
    check_val({tag, " post busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // reset held with start asserted
    rst   = 1'b1;
    start = 1'b1;
    cfg_len  = 5'd16;
    cfg_nbuf = 3'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet($sformatf("reset c%0d", i));
    end
    rst   = 1'b0;
    start = 1'b0;
    step();
    check_quiet("after reset");

    run_seq(16, 4, 16, 4, 1'b0, 1'b0, "full");
    run_seq(5, 2, 5, 2, 1'b1, 1'b0, "stall");
    run_seq(0, 7, 16, 4, 1'b0, 1'b0, "clamp");

    // abort after 20 beats, with an ignored start mid-run
    cfg_len  = 5'd16;
    cfg_nbuf = 3'd4;
    start    = 1'b1;
    advance  = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check_val($sformatf("abort run index b%0d", k), 32'(index), 32'(k % 16));
      check_val($sformatf("abort run buf b%0d", k), 32'(buf_sel), 32'(k / 16));
      if (k == 5) begin
        start    = 1'b1;
        cfg_len  = 5'd3;
        cfg_nbuf = 3'd1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    check_val("pre-abort index", 32'(index), 32'd4);
    check_val("pre-abort buf", 32'(buf_sel), 32'd1);
    check_val("pre-abort valid", 32'(valid), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_quiet("abort");
    step();
    check_quiet("abort settle");
    run_seq(3, 1, 3, 1, 1'b0, 1'b0, "restart");

    run_seq(1, 1, 1, 1, 1'b0, 1'b0, "len1 nbuf1");
    run_seq(1, 3, 1, 3, 1'b0, 1'b0, "len1 nbuf3");

    // abort together with start in IDLE
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check_quiet("abort+start idle");
    step();
    check_quiet("abort+start idle settle");

    // reset in the middle of a run
    cfg_len  = 5'd16;
    cfg_nbuf = 3'd4;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_val("midrst pre index", 32'(index), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_quiet("midrst");

`ifdef PROJ_IDX_SEQ_REVERSE_EN
    run_seq(4, 2, 4, 2, 1'b0, 1'b1, "reverse");
    run_seq(3, 2, 3, 2, 1'b1, 1'b1, "reverse stall");
    dir = 1'b0;
    run_seq(4, 1, 4, 1, 1'b0, 1'b0, "forward after reverse");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
